// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_if
//  Description : Serial line and received-byte signals of the UART receiver.
//                The slave modport is the receiver; the master modport is
//                the side that drives the line and consumes bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_if;
    logic       input_rx;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_error;
    logic       busy;

    modport master (
        output input_rx,
        input  data,
        input  data_valid,
        input  frame_error,
        input  busy
    );

    modport slave (
        input  input_rx,
        output data,
        output data_valid,
        output frame_error,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 UART receiver, LSB first. Two-flop line synchroniser,
//                mid-bit start validation and data sampling, stop-bit check
//                with one-cycle valid / frame-error strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int BAUDRATE = 115200,
    parameter int CLK_FREQ = 10000000
) (
    input  wire logic  clk,
    input  wire logic  rst,
    uart_rx_if.slave   bus
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUDRATE;
    localparam int HALF_BIT     = (CLKS_PER_BIT - 1) / 2;

    localparam logic [15:0] c_BIT_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] c_HALF_BIT = 16'(HALF_BIT);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_START     = 3'd1;
    localparam logic [2:0] c_DATA      = 3'd2;
    localparam logic [2:0] c_STOP      = 3'd3;
    localparam logic [2:0] c_WAIT_HIGH = 3'd4;

    // Mid-bit sampling needs room for at least a few cycles per bit.
    if (CLKS_PER_BIT < 4) begin : g_bad_cfg
        $error("uart_rx: CLK_FREQ / BAUDRATE must be at least 4");
    end

    logic [1:0]  r_sync;
    logic        w_rx_s;
    logic [2:0]  r_state;
    logic [15:0] r_clk_count;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic [7:0]  r_data;
    logic        r_data_valid;
    logic        r_frame_error;

    assign w_rx_s = r_sync[1];

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], bus.input_rx};
        end
    end

    // Frame state machine: start validation, data shift, stop check.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_IDLE;
            r_clk_count   <= 16'd0;
            r_bit_idx     <= 3'd0;
            r_shift       <= 8'h00;
            r_data        <= 8'h00;
            r_data_valid  <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_data_valid  <= 1'b0;
            r_frame_error <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    r_clk_count <= 16'd0;
                    if (!w_rx_s) begin
                        r_state <= c_START;
                    end
                end
                c_START: begin
                    if (r_clk_count == c_HALF_BIT) begin
                        r_clk_count <= 16'd0;
                        r_bit_idx   <= 3'd0;
                        // A line that is high again at mid-start was a glitch.
                        r_state     <= w_rx_s ? c_IDLE : c_DATA;
                    end else begin
                        r_clk_count <= r_clk_count + 16'd1;
                    end
                end
                c_DATA: begin
                    if (r_clk_count == c_BIT_LAST) begin
                        r_clk_count        <= 16'd0;
                        r_shift[r_bit_idx] <= w_rx_s;
                        r_bit_idx          <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= c_STOP;
                        end
                    end else begin
                        r_clk_count <= r_clk_count + 16'd1;
                    end
                end
                c_STOP: begin
                    if (r_clk_count == c_BIT_LAST) begin
                        r_clk_count <= 16'd0;
                        if (w_rx_s) begin
                            r_data       <= r_shift;
                            r_data_valid <= 1'b1;
                            r_state      <= c_IDLE;
                        end else begin
                            r_frame_error <= 1'b1;
                            r_state       <= c_WAIT_HIGH;
                        end
                    end else begin
                        r_clk_count <= r_clk_count + 16'd1;
                    end
                end
                c_WAIT_HIGH: begin
                    // Hold off until the line is released so a break is not
                    // mistaken for a new start bit.
                    if (w_rx_s) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.data        = r_data;
    assign bus.data_valid  = r_data_valid;
    assign bus.frame_error = r_frame_error;
    assign bus.busy        = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Scoreboard bench for uart_rx. One instance at 10 clk/bit,
//                one at the default 86 clk/bit driven by a bench transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    typedef struct packed {
        logic       fe;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    int   checks = 0;
    int   errors = 0;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea;
    exp_t eb;

    logic [7:0] last_a = 8'h00;
    int         t_fall_b = 0;
    bit         lat_arm = 1'b0;
    int         lat;

    uart_rx_if ifa ();
    uart_rx_if ifb ();

    uart_rx #(.BAUDRATE(1000000), .CLK_FREQ(10000000)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    uart_rx dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor for the 10 clk/bit instance.
    always @(negedge clk) begin
        if (!rst && (ifa.data_valid || ifa.frame_error)) begin
            checks++;
            if (ifa.data_valid && ifa.frame_error) begin
                errors++;
                $display("FAIL a_both_strobes: got dv=1 fe=1, expected at most one");
            end else if (qa.size() == 0) begin
                errors++;
                $display("FAIL a_unexpected: got dv=%0b fe=%0b data=%02h, expected no strobe",
                         ifa.data_valid, ifa.frame_error, ifa.data);
            end else begin
                ea = qa.pop_front();
                if (ea.fe !== ifa.frame_error || ea.data !== ifa.data) begin
                    errors++;
                    $display("FAIL a_frame: got fe=%0b data=%02h, expected fe=%0b data=%02h",
                             ifa.frame_error, ifa.data, ea.fe, ea.data);
                end
            end
        end
    end

    // Monitor for the default-rate instance, including latency.
    always @(negedge clk) begin
        if (!rst && (ifb.data_valid || ifb.frame_error)) begin
            checks++;
            if (qb.size() == 0) begin
                errors++;
                $display("FAIL b_unexpected: got dv=%0b fe=%0b data=%02h, expected no strobe",
                         ifb.data_valid, ifb.frame_error, ifb.data);
            end else begin
                eb = qb.pop_front();
                if (eb.fe !== ifb.frame_error || eb.data !== ifb.data) begin
                    errors++;
                    $display("FAIL b_frame: got fe=%0b data=%02h, expected fe=%0b data=%02h",
                             ifb.frame_error, ifb.data, eb.fe, eb.data);
                end
            end
            if (lat_arm && ifb.data_valid) begin
                checks++;
                lat = cyc - t_fall_b;
                if (lat < 819 || lat > 821) begin
                    errors++;
                    $display("FAIL b_latency: got %0d cycles, expected 819..821", lat);
                end
                lat_arm = 1'b0;
            end
        end
    end

    task automatic drive_bit(input bit which, input logic v, input int n);
        if (which) ifb.input_rx = v;
        else       ifa.input_rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input bit which, input logic [7:0] b, input logic stop_bit, input int cpb);
        if (which) t_fall_b = cyc;
        drive_bit(which, 1'b0, cpb);
        for (int i = 0; i < 8; i++) drive_bit(which, b[i], cpb);
        drive_bit(which, stop_bit, cpb);
    endtask

    task automatic good_a(input logic [7:0] b);
        qa.push_back(exp_t'({1'b0, b}));
        last_a = b;
        send_frame(1'b0, b, 1'b1, 10);
    endtask

    initial begin
        ifa.input_rx = 1'b1;
        ifb.input_rx = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_a_data", 32'(ifa.data), 32'h00);
        check("rst_a_dv",   32'(ifa.data_valid), 32'd0);
        check("rst_a_fe",   32'(ifa.frame_error), 32'd0);
        check("rst_a_busy", 32'(ifa.busy), 32'd0);
        check("rst_b_busy", 32'(ifb.busy), 32'd0);
        repeat (5) @(posedge clk);
        #1;

        // Short glitch while idle: rejected at mid-start
        drive_bit(1'b0, 1'b0, 3);
        drive_bit(1'b0, 1'b1, 2);
        check("glitch_busy_mid", 32'(ifa.busy), 32'd1);
        drive_bit(1'b0, 1'b1, 8);
        check("glitch_busy_end", 32'(ifa.busy), 32'd0);
        check("glitch_data",     32'(ifa.data), 32'h00);

        // Single frame 0xA5
        good_a(8'hA5);
        drive_bit(1'b0, 1'b1, 3);
        check("a5_busy_after", 32'(ifa.busy), 32'd0);
        check("a5_data_hold",  32'(ifa.data), 32'hA5);

        // Back-to-back 0x00 then 0xFF
        good_a(8'h00);
        good_a(8'hFF);
        drive_bit(1'b0, 1'b1, 5);
        check("b2b_busy_after", 32'(ifa.busy), 32'd0);

        // Frame error on 0x3C, line held low, then released
        qa.push_back(exp_t'({1'b1, last_a}));
        send_frame(1'b0, 8'h3C, 1'b0, 10);
        drive_bit(1'b0, 1'b0, 50);
        check("brk_busy_low", 32'(ifa.busy), 32'd1);
        drive_bit(1'b0, 1'b1, 4);
        check("brk_busy_rel", 32'(ifa.busy), 32'd0);
        check("brk_data_kept", 32'(ifa.data), 32'hFF);
        good_a(8'h41);
        drive_bit(1'b0, 1'b1, 5);

        // Reset in the middle of frame 0x77 (start + bits 1,1,1)
        drive_bit(1'b0, 1'b0, 10);
        drive_bit(1'b0, 1'b1, 30);
        check("mid_busy", 32'(ifa.busy), 32'd1);
        rst = 1'b1;
        ifa.input_rx = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("mid_rst_data", 32'(ifa.data), 32'h00);
        check("mid_rst_busy", 32'(ifa.busy), 32'd0);
        check("mid_rst_dv",   32'(ifa.data_valid), 32'd0);
        check("mid_rst_fe",   32'(ifa.frame_error), 32'd0);
        last_a = 8'h00;
        drive_bit(1'b0, 1'b1, 20);
        good_a(8'h12);
        drive_bit(1'b0, 1'b1, 5);
        check("post_rst_data", 32'(ifa.data), 32'h12);

        // Default rate: 0x61 from the bench transmitter, with latency
        qb.push_back(exp_t'({1'b0, 8'h61}));
        lat_arm = 1'b1;
        send_frame(1'b1, 8'h61, 1'b1, 86);
        drive_bit(1'b1, 1'b1, 20);
        check("b_data",     32'(ifb.data), 32'h61);
        check("b_busy",     32'(ifb.busy), 32'd0);
        check("b_lat_seen", 32'(lat_arm), 32'd0);

        // Every expected strobe must have been seen
        check("qa_drained", 32'(qa.size()), 32'd0);
        check("qb_drained", 32'(qb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
